// File: rtl/switch_arb_pkg.sv
// rtl/switch_arb_pkg.sv - shared types and helpers for the switch port arbiter
package switch_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int MAX_ONEHOT_W = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_ONEHOT_W-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_ONEHOT_W; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/switch_port_arbiter_rr_pick.sv
// rtl/switch_port_arbiter_rr_pick.sv - combinational round-robin winner search
module rr_pick
  import switch_arb_pkg::*;
#(
  parameter int NUM_OF_PORTS = 16,
  localparam int IDX_W = idx_w(NUM_OF_PORTS)
) (
  input  logic [NUM_OF_PORTS-1:0] req,
  input  logic [IDX_W-1:0]        rr_ptr,
  output logic [IDX_W-1:0]        winner,
  output logic                    found
);

  localparam logic [IDX_W:0] PORTS = (IDX_W+1)'(NUM_OF_PORTS);

  logic [2*NUM_OF_PORTS-1:0] req_dbl;
  logic [NUM_OF_PORTS-1:0]   hit;
  logic [IDX_W-1:0]          cand [NUM_OF_PORTS];

  assign req_dbl = {req, req};

  // Slot i looks at port rr_ptr+1+i; the doubled vector makes the wrap free.
  for (genvar i = 0; i < NUM_OF_PORTS; i++) begin : g_scan
    logic [IDX_W:0] pos;
    assign pos     = {1'b0, rr_ptr} + (IDX_W+1)'(i + 1);
    assign hit[i]  = req_dbl[pos];
    assign cand[i] = (pos >= PORTS) ? IDX_W'(pos - PORTS) : pos[IDX_W-1:0];
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int j = NUM_OF_PORTS - 1; j >= 0; j--) begin
      if (hit[j]) begin
        found  = 1'b1;
        winner = cand[j];
      end
    end
  end

endmodule

// File: rtl/switch_port_arbiter.sv
// rtl/switch_port_arbiter.sv - packet-granular round-robin egress arbiter
// Optional hold timeout enabled by defining SWITCH_ARB_TIMEOUT_EN.
module switch_port_arbiter
  import switch_arb_pkg::*;
#(
  parameter int NUM_OF_PORTS = 16,
  parameter int MAX_HOLD     = 256,
  localparam int IDX_W = idx_w(NUM_OF_PORTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_OF_PORTS-1:0] req,
  input  logic [NUM_OF_PORTS-1:0] in_valid,
  input  logic [NUM_OF_PORTS-1:0] in_last,
  output logic [NUM_OF_PORTS-1:0] in_ready,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [NUM_OF_PORTS-1:0] grant,
  output logic [IDX_W-1:0]        out_sel,
  output logic                    busy,
  output logic                    timeout
);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic             accept;
  logic             done;
  logic             expire;

  rr_pick #(.NUM_OF_PORTS(NUM_OF_PORTS)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .found  (found)
  );

  // grant is zero outside GRANT, so masking by it gates every egress path.
  assign in_ready  = grant & {NUM_OF_PORTS{out_ready}};
  assign out_valid = |(grant & in_valid);
  assign out_last  = |(grant & in_valid & in_last);
  assign accept    = out_valid & out_ready;
  assign done      = accept & out_last;

`ifdef SWITCH_ARB_TIMEOUT_EN
  localparam int HOLD_W = idx_w(MAX_HOLD);
  logic [HOLD_W-1:0] hold_cnt;

  assign expire = (state == GRANT) && !accept && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= expire;
      if (state != GRANT || accept) hold_cnt <= '0;
      else                          hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      out_sel <= '0;
      busy    <= 1'b0;
      rr_ptr  <= IDX_W'(NUM_OF_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state   <= GRANT;
            grant   <= NUM_OF_PORTS'(1) << winner;
            out_sel <= winner;
            busy    <= 1'b1;
          end
        end
        GRANT: begin
          // The released port becomes lowest priority for the next search.
          if (done || expire) begin
            state  <= IDLE;
            grant  <= '0;
            busy   <= 1'b0;
            rr_ptr <= out_sel;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_port_arbiter.sv
// tb/tb_switch_port_arbiter.sv - directed and randomized checks of switch_port_arbiter
module tb_switch_port_arbiter;

  localparam int N    = 16;
  localparam int IW   = 4;
  localparam int MAXH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, in_valid, in_last, in_ready, grant;
  logic          out_valid, out_last, out_ready, busy, timeout;
  logic [IW-1:0] out_sel;

  int checks = 0;
  int errors = 0;
  int g_ptr;

  always #5 clk = ~clk;

  switch_port_arbiter #(.NUM_OF_PORTS(N), .MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .out_sel   (out_sel),
    .busy      (busy),
    .timeout   (timeout)
  );

  // First requesting port strictly after ptr, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] v,
                        input logic [N-1:0] l, input logic rdy);
    @(negedge clk);
    req = r; in_valid = v; in_last = l; out_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; in_valid = '0; in_last = '0; out_ready = 1'b0;
    #12;
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got %h exp %h", grant, 16'h0); end
    checks++; if (out_sel !== '0) begin errors++; $display("FAIL reset_out_sel got %0d exp 0", out_sel); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    set_in('0, '1, '1, 1'b1);
    checks++; if ({out_valid, out_last, in_ready} !== '0) begin errors++; $display("FAIL reset_paths got %b %b %h exp 0 0 0", out_valid, out_last, in_ready); end
    @(negedge clk); rst = 1'b0;
    g_ptr = N - 1;
  endtask

  task automatic test_single();
    set_in(16'h0004, '0, '0, 1'b1);
    checks++; if (grant !== '0) begin errors++; $display("FAIL single_latency got %h exp %h", grant, 16'h0); end
    set_in('0, 16'h0004, '0, 1'b1);
    checks++; if (grant !== 16'h0004) begin errors++; $display("FAIL single_grant got %h exp %h", grant, 16'h0004); end
    checks++; if (out_sel !== 4'd2) begin errors++; $display("FAIL single_out_sel got %0d exp 2", out_sel); end
    checks++; if (in_ready !== 16'h0004 || out_valid !== 1'b1) begin errors++; $display("FAIL single_beat1 got rdy %h v %b exp 0004 1", in_ready, out_valid); end
    set_in(16'h0000, 16'h0004, 16'h0004, 1'b1);
    checks++; if (busy !== 1'b1 || out_last !== 1'b1) begin errors++; $display("FAIL single_last got busy %b last %b exp 1 1", busy, out_last); end
    set_in('0, '0, '0, 1'b1);
    checks++; if (grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL single_release got %h %b exp 0 0", grant, busy); end
    g_ptr = 2;
  endtask

  task automatic test_backpressure();
    logic rdy;
    set_in(16'h0020, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rdy = (i % 2 == 0);
      set_in('0, 16'h0020, (i >= 1) ? 16'h0020 : 16'h0000, rdy);
      checks++; if (grant !== 16'h0020) begin errors++; $display("FAIL bp_grant_%0d got %h exp %h", i, grant, 16'h0020); end
      checks++; if (in_ready !== (rdy ? 16'h0020 : 16'h0000)) begin errors++; $display("FAIL bp_in_ready_%0d got %h exp %h", i, in_ready, rdy ? 16'h0020 : 16'h0000); end
    end
    set_in('0, '0, '0, 1'b0);
    checks++; if (grant !== '0) begin errors++; $display("FAIL bp_release got %h exp 0", grant); end
    g_ptr = 5;
  endtask

  task automatic test_contention();
    int exp;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    g_ptr = N - 1;
    for (int pk = 0; pk <= N; pk++) begin
      set_in('1, '1, '0, 1'b1);
      checks++; if (grant !== '0) begin errors++; $display("FAIL cont_bubble_%0d got %h exp 0", pk, grant); end
      exp = pick('1, g_ptr);
      checks++; if (exp != pk % N) begin errors++; $display("FAIL cont_order_%0d got %0d exp %0d", pk, exp, pk % N); end
      for (int b = 0; b < 3; b++) begin
        set_in('1, '1, (b == 2) ? '1 : '0, 1'b1);
        checks++; if (grant !== (N'(1) << exp) || out_sel !== IW'(exp)) begin errors++; $display("FAIL cont_grant_%0d_%0d got %h sel %0d exp port %0d", pk, b, grant, out_sel, exp); end
      end
      g_ptr = exp;
    end
    set_in('0, '0, '0, 1'b1);
  endtask

  task automatic test_wrap();
    int exp_tab [2] = '{15, 0};
    for (int i = 0; i < 2; i++) begin
      set_in(16'h8001, '0, '0, 1'b1);
      set_in('0, '1, '1, 1'b1);
      checks++; if (grant !== (N'(1) << exp_tab[i]) || pick(16'h8001, g_ptr) != exp_tab[i]) begin errors++; $display("FAIL wrap_%0d got %h exp port %0d", i, grant, exp_tab[i]); end
      set_in('0, '0, '0, 1'b1);
      checks++; if (grant !== '0) begin errors++; $display("FAIL wrap_single_beat_%0d got %h exp 0", i, grant); end
      g_ptr = exp_tab[i];
    end
  endtask

  task automatic test_mid_reset();
    set_in(16'h0080, '0, '0, 1'b1);
    set_in('0, 16'h0080, '0, 1'b1);
    checks++; if (grant !== 16'h0080) begin errors++; $display("FAIL midrst_grant got %h exp %h", grant, 16'h0080); end
    set_in('0, 16'h0080, '0, 1'b1);
    #1 rst = 1'b1;
    #1;
    checks++; if (grant !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_async got %h %b %b exp 0 0 0", grant, out_valid, busy); end
    @(negedge clk); rst = 1'b0;
    set_in('1, '0, '0, 1'b1);
    set_in('0, 16'h0001, 16'h0001, 1'b1);
    checks++; if (grant !== 16'h0001) begin errors++; $display("FAIL midrst_restart got %h exp %h", grant, 16'h0001); end
    set_in('0, '0, '0, 1'b1);
    g_ptr = 0;
  endtask

`ifdef SWITCH_ARB_TIMEOUT_EN
  task automatic test_timeout();
    set_in(16'h0008, '0, '0, 1'b1);
    for (int i = 0; i < MAXH; i++) begin
      set_in('0, '0, '0, 1'b1);
      checks++; if (grant !== 16'h0008 || timeout !== 1'b0) begin errors++; $display("FAIL to_hold_%0d got %h %b exp 0008 0", i, grant, timeout); end
    end
    set_in(16'h0018, '0, '0, 1'b1);
    checks++; if (grant !== '0 || timeout !== 1'b1) begin errors++; $display("FAIL to_release got %h %b exp 0 1", grant, timeout); end
    set_in('0, 16'h0010, 16'h0010, 1'b1);
    checks++; if (grant !== 16'h0010 || timeout !== 1'b0) begin errors++; $display("FAIL to_next got %h %b exp 0010 0", grant, timeout); end
    set_in('0, '0, '0, 1'b1);
    g_ptr = 4;
  endtask
`endif

  task automatic test_random();
    bit m_busy = 1'b0, m_to = 1'b0;
    int m_sel = 0, m_ptr, m_idle = 0;
    logic [N-1:0] r, v, l, exp_g;
    logic rdy;
    m_ptr = g_ptr;
    for (int c = 0; c < 600; c++) begin
      r   = N'($urandom) & N'($urandom) & N'($urandom);
      v   = N'($urandom) | N'($urandom);
      l   = N'($urandom) & N'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      set_in(r, v, l, rdy);
      exp_g = m_busy ? (N'(1) << m_sel) : '0;
      checks++; if (grant !== exp_g || busy !== m_busy) begin errors++; $display("FAIL rand_grant_%0d got %h %b exp %h %b", c, grant, busy, exp_g, m_busy); end
      checks++; if (in_ready !== (exp_g & {N{rdy}})) begin errors++; $display("FAIL rand_in_ready_%0d got %h exp %h", c, in_ready, exp_g & {N{rdy}}); end
      checks++; if (out_valid !== (m_busy && v[m_sel]) || out_last !== (m_busy && v[m_sel] && l[m_sel])) begin errors++; $display("FAIL rand_egress_%0d got %b%b exp %b%b", c, out_valid, out_last, m_busy && v[m_sel], m_busy && v[m_sel] && l[m_sel]); end
      checks++; if (timeout !== m_to) begin errors++; $display("FAIL rand_timeout_%0d got %b exp %b", c, timeout, m_to); end
      m_to = 1'b0;
      if (!m_busy) begin
        if (r != '0) begin m_sel = pick(r, m_ptr); m_busy = 1'b1; m_idle = 0; end
      end else if (v[m_sel] && rdy) begin
        m_idle = 0;
        if (l[m_sel]) begin m_busy = 1'b0; m_ptr = m_sel; end
      end else begin
        m_idle++;
`ifdef SWITCH_ARB_TIMEOUT_EN
        if (m_idle == MAXH) begin m_busy = 1'b0; m_ptr = m_sel; m_to = 1'b1; end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_contention();
    test_wrap();
    test_mid_reset();
`ifdef SWITCH_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
